// File: rtl/alu32_if.sv
// Operand/result bundle between an ALU client and alu32.
// The client drives operands and opcode; the ALU returns the registered result and flags.
interface alu32_if;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [2:0]  ctrl;
  logic [31:0] out;
  logic        oCarry;
  logic        oZero;

  modport master (output data1, data2, ctrl, input  out, oCarry, oZero);
  modport slave  (input  data1, data2, ctrl, output out, oCarry, oZero);
endinterface

// File: rtl/alu32.sv
// 32-bit single-cycle ALU with registered result, carry/borrow and zero flags.
// Optional macro ALU32_EXT_OPS_EN enables SLL/SRL/SLTU on opcodes 101..111.
module alu32 (
  input  logic     clk,
  input  logic     rst,
  alu32_if.slave   bus
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_XOR  = 3'b011,
    OP_OR   = 3'b100,
    OP_SLL  = 3'b101,
    OP_SRL  = 3'b110,
    OP_SLTU = 3'b111
  } op_e;

  logic [31:0] out_q, out_d;
  logic        carry_q, carry_d;
  logic        zero_q, zero_d;
  logic [32:0] sum33, diff33;

  // 33-bit arithmetic so bit 32 is the carry (ADD) or the unsigned borrow (SUB).
  assign sum33  = {1'b0, bus.data1} + {1'b0, bus.data2};
  assign diff33 = {1'b0, bus.data1} - {1'b0, bus.data2};

  always_comb begin
    out_d   = 32'h0;
    carry_d = 1'b0;
    case (op_e'(bus.ctrl))
      OP_ADD: begin
        out_d   = sum33[31:0];
        carry_d = sum33[32];
      end
      OP_SUB: begin
        out_d   = diff33[31:0];
        carry_d = diff33[32];
      end
      OP_AND: out_d = bus.data1 & bus.data2;
      OP_XOR: out_d = bus.data1 ^ bus.data2;
      OP_OR:  out_d = bus.data1 | bus.data2;
`ifdef ALU32_EXT_OPS_EN
      OP_SLL:  out_d = bus.data1 << bus.data2[4:0];
      OP_SRL:  out_d = bus.data1 >> bus.data2[4:0];
      OP_SLTU: out_d = {31'h0, diff33[32]};
`else
      OP_SLL, OP_SRL, OP_SLTU: out_d = 32'h0;
`endif
      default: out_d = 32'h0;
    endcase
    zero_d = (out_d == 32'h0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= 32'h0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      out_q   <= out_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.out    = out_q;
  assign bus.oCarry = carry_q;
  assign bus.oZero  = zero_q;

endmodule

// File: tb/tb_alu32.sv
// Directed-vector bench for alu32: arithmetic/logic corners, latency, async reset, extended ops.
module tb_alu32;

  logic clk;
  logic rst;
  int   nchk;
  int   nerr;

  alu32_if bus();

  alu32 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [31:0] eo, input logic ec, input logic ez);
    chk({tag, ".out"},   bus.out,             eo);
    chk({tag, ".carry"}, {31'h0, bus.oCarry}, {31'h0, ec});
    chk({tag, ".zero"},  {31'h0, bus.oZero},  {31'h0, ez});
  endtask

  // Drive operands mid-cycle, then sample just after the loading edge.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eo, input logic ec,
                        input logic ez);
    @(negedge clk);
    bus.ctrl  = op;
    bus.data1 = a;
    bus.data2 = b;
    @(posedge clk);
    #1;
    chk3(tag, eo, ec, ez);
  endtask

  initial begin
    nchk      = 0;
    nerr      = 0;
    rst       = 1'b1;
    bus.ctrl  = 3'b000;
    bus.data1 = 32'h1234_5678;
    bus.data2 = 32'h1111_1111;
    #2;
    chk3("reset_async", 32'h0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk3("reset_held", 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    run_op("add_ff_ff",  3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0);
    run_op("add_ff_1",   3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1);
    run_op("add_small",  3'b000, 32'h0000_0007, 32'h0000_0009, 32'h0000_0010, 1'b0, 1'b0);
    run_op("sub_ff_ff",  3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1);
    run_op("sub_ff_1",   3'b001, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op("sub_0_0",    3'b001, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1);
    run_op("sub_0_1",    3'b001, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op("and_bit19",  3'b010, 32'hFFFF_FFFF, 32'h0008_0000, 32'h0008_0000, 1'b0, 1'b0);
    run_op("xor_same",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1);
    run_op("xor_zero",   3'b011, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("or_fe",      3'b100, 32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op("or_mix",     3'b100, 32'hA500_0000, 32'h005A_0000, 32'hA55A_0000, 1'b0, 1'b0);

    // Latency: operands change half a cycle before the edge; old result must hold.
    run_op("lat_base",   3'b000, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0);
    @(negedge clk);
    bus.data1 = 32'h0000_0005;
    bus.data2 = 32'h0000_0005;
    #3;
    chk3("lat_hold", 32'h0000_0003, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk3("lat_update", 32'h0000_000A, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk3("lat_stable", 32'h0000_000A, 1'b0, 1'b0);

    // Async reset mid-operation.
    run_op("rst_pre",    3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk3("rst_immediate", 32'h0, 1'b0, 1'b1);
    bus.ctrl  = 3'b001;
    bus.data1 = 32'h0000_0000;
    bus.data2 = 32'h0000_0001;
    @(posedge clk);
    #1;
    chk3("rst_discard", 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk3("rst_first_load", 32'hFFFF_FFFF, 1'b1, 1'b0);

`ifdef ALU32_EXT_OPS_EN
    run_op("sll_1_4",    3'b101, 32'h0000_0001, 32'h0000_0004, 32'h0000_0010, 1'b0, 1'b0);
    run_op("sll_wrapsh", 3'b101, 32'h0000_0003, 32'h0000_0021, 32'h0000_0006, 1'b0, 1'b0);
    run_op("srl_80_3",   3'b110, 32'h0000_0080, 32'h0000_0003, 32'h0000_0010, 1'b0, 1'b0);
    run_op("sltu_1_2",   3'b111, 32'h0000_0001, 32'h0000_0002, 32'h0000_0001, 1'b0, 1'b0);
    run_op("sltu_2_1",   3'b111, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1);
`else
    run_op("ext101_off", 3'b101, 32'h0000_0001, 32'h0000_0004, 32'h0000_0000, 1'b0, 1'b1);
    run_op("ext110_off", 3'b110, 32'h0000_0080, 32'h0000_0003, 32'h0000_0000, 1'b0, 1'b1);
    run_op("ext111_off", 3'b111, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 1'b0, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/alu32.md
ALU32 -- requirements
Module: alu32

Interface
REQ-001 Parameters: none; datapath width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 data1  input  32  operand A, unsigned.
REQ-005 data2  input  32  operand B, unsigned.
REQ-006 ctrl  input  3  operation select.
REQ-007 out  output  32  registered result.
REQ-008 oCarry  output  1  registered carry/borrow flag.
REQ-009 oZero  output  1  registered zero flag.

Function
REQ-010 Opcodes: 000 ADD, 001 SUB, 010 AND, 011 XOR, 100 OR; 101..111 are extended ops (see Configuration).
REQ-011 Inputs are sampled on each rising clk edge; out, oCarry and oZero reflect the sampled operands/ctrl after that edge, giving 1-cycle latency with no handshake.
REQ-012 ADD: out = (data1 + data2) mod 2^32; oCarry = bit 32 of the 33-bit sum.
REQ-013 SUB: out = (data1 - data2) mod 2^32; oCarry = 1 iff data1 < data2 (unsigned borrow), else 0.
REQ-014 AND/XOR/OR: bitwise over all 32 bits; oCarry = 0.
REQ-015 oZero = 1 iff the registered out value equals 32'h0, in every opcode, including wrap-around results.
REQ-016 Inputs changing between edges have no effect on the outputs until the next rising edge.
REQ-017 All three outputs update together on the same edge; no partial update.

Reset
REQ-018 While rst=1: out = 32'h0, oCarry = 0, oZero = 1, applied immediately without waiting for clk.
REQ-019 Reset asserted mid-operation discards the pending result; the first result after deassertion comes from the operands sampled on the first rising edge with rst=0.

Configuration
REQ-020 Macro ALU32_EXT_OPS_EN: when defined, 101 = logical shift left data1 by data2[4:0], 110 = logical shift right data1 by data2[4:0], 111 = unsigned set-less-than (out = 32'h1 if data1 < data2, else 32'h0); oCarry = 0 for all three.
REQ-021 Without ALU32_EXT_OPS_EN, opcodes 101..111 produce out = 32'h0, oCarry = 0 and oZero = 1.

Verification
REQ-022 ADD FFFFFFFF + FFFFFFFF -> next edge: out=FFFFFFFE, oCarry=1, oZero=0; ADD FFFFFFFF + 00000001 -> out=00000000, oCarry=1, oZero=1.
REQ-023 SUB FFFFFFFF - FFFFFFFF -> out=0, oCarry=0, oZero=1; SUB FFFFFFFF - 00000001 -> out=FFFFFFFE, oCarry=0; SUB 0 - 0 -> out=0, oZero=1; SUB 0 - 1 -> out=FFFFFFFF, oCarry=1.
REQ-024 Logic ops: AND FFFFFFFF & 00080000 -> 00080000; XOR FFFFFFFF ^ FFFFFFFF -> 0 with oZero=1; XOR FFFFFFFF ^ 0 -> FFFFFFFF; OR FFFFFFFE | 0 -> FFFFFFFE; oCarry=0 in all cases.
REQ-025 Latency: change the operands half a cycle before an edge and confirm the outputs hold their old values until that edge and then update exactly once.
REQ-026 Reset: assert rst between edges while out=FFFFFFFE -> out=0, oCarry=0, oZero=1 immediately; after deassertion, the first edge loads the new result.
REQ-027 Extended ops: with the macro, ctrl=101 on data1=1, data2=4 -> out=00000010 and ctrl=111 on data1=1, data2=2 -> out=00000001; without the macro, ctrl=101 -> out=0, oZero=1.
